// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU sharing arbiter.
package alu_share_arbiter_pkg;

    localparam int unsigned ALU_W = 32;
    localparam int unsigned REQ_N = 2;
    localparam int unsigned OPC_W = 5;
    localparam int unsigned F3_W  = 3;

    localparam logic [OPC_W-1:0] OP_R     = 5'b01100;
    localparam logic [OPC_W-1:0] OP_I     = 5'b00100;
    localparam logic [OPC_W-1:0] OP_LUI   = 5'b01101;
    localparam logic [OPC_W-1:0] OP_AUIPC = 5'b00101;
    localparam logic [OPC_W-1:0] OP_LOAD  = 5'b00000;
    localparam logic [OPC_W-1:0] OP_STORE = 5'b01000;
    localparam logic [OPC_W-1:0] OP_JAL   = 5'b11011;
    localparam logic [OPC_W-1:0] OP_JALR  = 5'b11001;
    localparam logic [OPC_W-1:0] OP_BR    = 5'b11000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [F3_W-1:0]  func3;
        logic             func7;
        logic [ALU_W-1:0] op1;
        logic [ALU_W-1:0] op2;
    } alu_req_t;

    // Branch func3 010/011 have no compare defined; everything else listed is legal.
    function automatic logic is_legal(input logic [OPC_W-1:0] opc, input logic [F3_W-1:0] f3);
        logic ok;
        case (opc)
            OP_R, OP_I, OP_LUI, OP_AUIPC,
            OP_LOAD, OP_STORE, OP_JAL, OP_JALR: ok = 1'b1;
            OP_BR:   ok = (f3 != 3'b010) && (f3 != 3'b011);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational RV32-style ALU evaluated from a latched request payload.
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
(
    input  alu_req_t         req,
    output logic [ALU_W-1:0] result
);

    logic [4:0]       shamt;
    logic [ALU_W-1:0] sum;
    logic [ALU_W-1:0] diff;
    logic             lt_s;
    logic             lt_u;
    logic             eq;

    always_comb begin
        shamt = req.op2[4:0];
        sum   = req.op1 + req.op2;
        diff  = req.op1 - req.op2;
        lt_s  = $signed(req.op1) < $signed(req.op2);
        lt_u  = req.op1 < req.op2;
        eq    = req.op1 == req.op2;
        result = '0;
        case (req.opcode)
            OP_R, OP_I: begin
                case (req.func3)
                    3'b000:  result = (req.opcode == OP_R && req.func7) ? diff : sum;
                    3'b001:  result = req.op1 << shamt;
                    3'b010:  result = ALU_W'(lt_s);
                    3'b011:  result = ALU_W'(lt_u);
                    3'b100:  result = req.op1 ^ req.op2;
                    3'b101:  result = req.func7 ? ALU_W'($signed(req.op1) >>> shamt)
                                                : req.op1 >> shamt;
                    3'b110:  result = req.op1 | req.op2;
                    default: result = req.op1 & req.op2;
                endcase
            end
            OP_LUI:                      result = req.op2;
            OP_AUIPC, OP_LOAD, OP_STORE: result = sum;
            OP_JAL, OP_JALR:             result = req.op1 + ALU_W'(4);
            OP_BR: begin
                case (req.func3)
                    3'b000:  result = ALU_W'(eq);
                    3'b001:  result = ALU_W'(!eq);
                    3'b100:  result = ALU_W'(lt_s);
                    3'b101:  result = ALU_W'(!lt_s);
                    3'b110:  result = ALU_W'(lt_u);
                    3'b111:  result = ALU_W'(!lt_u);
                    default: result = '0;
                endcase
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between the EX stage (req 0) and the aux unit (req 1).
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREQ   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*OPC_W-1:0]   req_opcode,
    input  logic [NREQ*F3_W-1:0]    req_func3,
    input  logic [NREQ-1:0]         req_func7,
    input  logic [NREQ*DATA_W-1:0]  req_op1,
    input  logic [NREQ*DATA_W-1:0]  req_op2,
    input  logic                    flush,
    output logic [NREQ-1:0]         resp_valid,
    input  logic [NREQ-1:0]         resp_ready,
    output logic [DATA_W-1:0]       resp_data,
    output logic                    resp_illegal,
    output logic                    busy
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    alu_req_t          req_q, req_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_illegal_q, resp_illegal_d;

    alu_req_t          cand [NREQ];
    logic              any_valid;
    logic              other;
    logic              win;
    logic              legal;
    logic [ALU_W-1:0]  alu_result;

    // Unpack the flat per-requester buses into payload structs.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand[i].opcode = req_opcode[i*OPC_W +: OPC_W];
            cand[i].func3  = req_func3[i*F3_W +: F3_W];
            cand[i].func7  = req_func7[i];
            cand[i].op1    = req_op1[i*DATA_W +: DATA_W];
            cand[i].op2    = req_op2[i*DATA_W +: DATA_W];
        end
    end

    // The requester that did not win last time has priority.
    always_comb begin
        any_valid = |req_valid;
        other     = ~last_grant_q;
        win       = req_valid[other] ? other : last_grant_q;
    end

    alu_share_arbiter_alu u_alu (
        .req    (req_q),
        .result (alu_result)
    );

    assign legal = is_legal(req_q.opcode, req_q.func3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            req_q          <= '0;
            resp_data_q    <= '0;
            resp_illegal_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            req_q          <= req_d;
            resp_data_q    <= resp_data_d;
            resp_illegal_q <= resp_illegal_d;
        end
    end

    // Next-state: a completed handshake and a flush both return to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid) state_d = EXEC;
            EXEC:    state_d = flush ? IDLE : RESP;
            RESP:    if (flush || resp_ready[last_grant_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture at grant, result capture at the end of EXEC.
    always_comb begin
        req_d          = req_q;
        last_grant_d   = last_grant_q;
        resp_data_d    = resp_data_q;
        resp_illegal_d = resp_illegal_q;
        if (state_q == IDLE && any_valid) begin
            req_d        = cand[win];
            last_grant_d = win;
        end
        if (state_q == EXEC && !flush) begin
            resp_data_d    = legal ? DATA_W'(alu_result) : '0;
            resp_illegal_d = !legal;
        end
    end

    // Outputs decoded from state; last_grant_q names the requester being served.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        busy       = (state_q != IDLE);
        if (state_q == IDLE && any_valid && !rst) req_ready[win] = 1'b1;
        if (state_q == RESP) resp_valid[last_grant_q] = 1'b1;
    end

    assign resp_data    = resp_data_q;
    assign resp_illegal = resp_illegal_q;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one combinational ALU between two requesters: requester 0 is the main pipeline EX stage, requester 1 is the auxiliary unit (branch-compare / address calc). Round-robin arbitration with a valid/ready handshake on both the request and response sides. Operands are latched, the ALU is evaluated from those registers, and the result is held in a response register until it is accepted. Fixed three-phase sequencing (IDLE, EXEC, RESP); one transaction in flight.

Parameters:
DATA_W, 32, operand/result width (ALU fixed at 32; other values unsupported)
NREQ, 2, requester count (fixed at 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  2  bit i = requester i has a request
req_ready  out  2  bit i = request i accepted this cycle
req_opcode  in  10  requester i at [i*5 +: 5], instr[6:2] opcode
req_func3  in  6  requester i at [i*3 +: 3]
req_func7  in  2  bit i = instr[30] of requester i
req_op1  in  64  requester i at [i*32 +: 32]
req_op2  in  64  requester i at [i*32 +: 32]
flush  in  1  abort the in-flight transaction
resp_valid  out  2  one-hot, response for requester i
resp_ready  in  2  requester i accepts the response
resp_data  out  32  ALU result (shared by both requesters)
resp_illegal  out  1  opcode/func3 combination not supported; resp_data = 0
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; req_ready=0, resp_valid=0, resp_data=0, resp_illegal=0, busy=0; last_grant=1, so requester 0 wins the first tie. Any in-flight transaction is dropped and no response is issued.
- IDLE:
  - If any req_valid, pick the winner g: the requester not equal to last_grant if it is valid, else the other.
  - req_ready[g]=1 combinationally in the same cycle. The loser sees ready=0 and must hold its request.
  - Latch opcode, func3, func7, op1 and op2 of g. Set last_grant=g. Next state is EXEC.
  - req_ready is 0 in every other state.
- EXEC: the ALU evaluates the latched operands. Register the result into resp_data and the legality check into resp_illegal. Next state is RESP.
- RESP:
  - resp_valid[g]=1; resp_data and resp_illegal held stable.
  - On resp_ready[g]=1, go to IDLE next cycle and clear resp_valid.
  - resp_ready of the other requester is ignored.
- Latency and throughput: accept at cycle T gives resp_valid at T+2. Minimum 3 cycles per transaction.
- flush:
  - In EXEC or RESP: go to IDLE next cycle with no response (resp_valid cleared).
  - In IDLE: no effect; a grant still proceeds.
  - flush together with the RESP handshake in the same cycle: the handshake counts and the state goes to IDLE.
- Legal set (else resp_illegal=1, resp_data=0):
  - opcodes 01100, 00100, 01101, 00101, 00000, 01000, 11011, 11001 with any func3;
  - opcode 11000 with func3 in {000, 001, 100, 101, 110, 111}.
- Arithmetic: 32-bit wraparound with no overflow flag. Shift amount is op2[4:0]. Branch opcode returns 1/0 compare. JAL/JALR return op1+4.
- Fairness: alternating grants whenever both are continuously valid. Neither requester waits more than one transaction.

Decomposition:
- Shared package: opcode constants (OP_R=01100, OP_I=00100, OP_LUI=01101, OP_AUIPC=00101, OP_LOAD=00000, OP_STORE=01000, OP_JAL=11011, OP_JALR=11001, OP_BR=11000); state enum {IDLE, EXEC, RESP}.
- One sub-module: instantiate the existing combinational ALU, driven only from the latched operand registers.
- Arbitration and legality decode stay inline.

Test Plan:
- Single op: r0 ADD (opcode 01100, f3 000, f7 0), op1=5, op2=7, resp_ready=1 -> req_ready[0] at T, resp_valid=01 at T+2 with resp_data=12, illegal=0.
- Contention: both valid from reset; r0 SUB 3-5, r1 SLTU 1<2 -> r0 served first with resp_data=0xFFFFFFFE, then r1 with resp_data=1; req_ready never 11.
- Backpressure: r1 branch BLT (f3 100), op1=0xFFFFFFFF, op2=0, resp_ready low for 4 cycles -> resp_valid=10 and resp_data=1 held stable; IDLE one cycle after ready rises.
- Illegal: r0 opcode 11000, f3 010 -> resp_illegal=1, resp_data=0.
- Flush: accept r0 SRA (00100, f3 101, f7 1) 0x80000000>>>4, assert flush in EXEC -> no resp_valid; the next request is granted normally.
- Async reset: assert rst in RESP between clock edges -> resp_valid, busy and resp_data go to 0 immediately; after release, a simultaneous request is granted to r0.
